// File: rtl/gpr_writeback_arbiter.sv
// gpr_writeback_arbiter
// Writeback stage feeding the GPR file's single write port. Buffers one
// completed result per source (EXU, LSU), picks one per cycle with an
// LSU-priority / EXU anti-starvation policy, and drives the write port
// from registers. Writes to x0 and retire-only results are dropped from
// the write port but still counted as retired.
module gpr_writeback_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic                  exu_wen,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic                  lsu_wen,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  gpr_w_en,
   output logic [ADDR_WIDTH-1:0] gpr_w_addr,
   output logic [DATA_WIDTH-1:0] gpr_w_data,
   output logic [63:0]           retire_cnt,
   output logic                  busy
);

   localparam logic [1:0] STREAK_MAX = 2'd3;

   // Holding slots (stage p0): one buffered result per source
   logic                  exu_vld_p0;
   logic                  exu_wen_p0;
   logic [ADDR_WIDTH-1:0] exu_rd_p0;
   logic [DATA_WIDTH-1:0] exu_data_p0;
   logic                  lsu_vld_p0;
   logic                  lsu_wen_p0;
   logic [ADDR_WIDTH-1:0] lsu_rd_p0;
   logic [DATA_WIDTH-1:0] lsu_data_p0;

   logic [1:0]            lsu_streak;
   logic                  grant_exu;
   logic                  grant_lsu;
   logic                  exu_hs;
   logic                  lsu_hs;
   logic                  sel_wen;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [63:0]           cnt_q;

   // Arbitration looks only at slot state so ready never depends on valid
   always_comb begin
      grant_exu = exu_vld_p0 && (!lsu_vld_p0 || (lsu_streak == STREAK_MAX));
      grant_lsu = lsu_vld_p0 && !grant_exu;
   end

   // A slot can take a new result when empty or when it drains this cycle
   assign exu_ready = rst_n && (!exu_vld_p0 || grant_exu);
   assign lsu_ready = rst_n && (!lsu_vld_p0 || grant_lsu);
   assign exu_hs    = exu_valid && exu_ready;
   assign lsu_hs    = lsu_valid && lsu_ready;

   // Slot occupancy: a handshake wins over a grant so the slot is reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exu_vld_p0 <= 1'b0;
         lsu_vld_p0 <= 1'b0;
      end else begin
         if (exu_hs)         exu_vld_p0 <= 1'b1;
         else if (grant_exu) exu_vld_p0 <= 1'b0;
         if (lsu_hs)         lsu_vld_p0 <= 1'b1;
         else if (grant_lsu) lsu_vld_p0 <= 1'b0;
      end
   end

   // Slot payloads are qualified by the valid bits and need no reset
   always_ff @(posedge clk) begin
      if (exu_hs) begin
         exu_wen_p0  <= exu_wen;
         exu_rd_p0   <= exu_rd;
         exu_data_p0 <= exu_data;
      end
      if (lsu_hs) begin
         lsu_wen_p0  <= lsu_wen;
         lsu_rd_p0   <= lsu_rd;
         lsu_data_p0 <= lsu_data;
      end
   end

   // Count LSU wins while EXU is waiting; EXU takes the port after three
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lsu_streak <= 2'd0;
      end else if (grant_exu || !exu_vld_p0) begin
         lsu_streak <= 2'd0;
      end else if (grant_lsu && (lsu_streak != STREAK_MAX)) begin
         lsu_streak <= lsu_streak + 2'd1;
      end
   end

   // Select the granted slot's payload for the write port
   always_comb begin
      sel_wen  = exu_wen_p0;
      sel_rd   = exu_rd_p0;
      sel_data = exu_data_p0;
      if (grant_lsu) begin
         sel_wen  = lsu_wen_p0;
         sel_rd   = lsu_rd_p0;
         sel_data = lsu_data_p0;
      end
   end

   // Write port (stage p1): one-cycle enable pulse per grant, x0 suppressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpr_w_en   <= 1'b0;
         gpr_w_addr <= '0;
         gpr_w_data <= '0;
      end else if (grant_exu || grant_lsu) begin
         gpr_w_en   <= sel_wen && (sel_rd != '0);
         gpr_w_addr <= sel_rd;
         gpr_w_data <= sel_data;
      end else begin
         gpr_w_en   <= 1'b0;
      end
   end

   // Every grant retires a result, whether or not it writes a register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 64'd0;
      end else if (grant_exu || grant_lsu) begin
         cnt_q <= cnt_q + 64'd1;
      end
   end

   assign retire_cnt = cnt_q;
   assign busy       = exu_vld_p0 || lsu_vld_p0 || gpr_w_en;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed bench for gpr_writeback_arbiter: a table of single/dual result
// vectors plus hand sequences for streaming, arbitration fairness, reset
// mid-operation and retire counter wrap.
module tb_gpr_writeback_arbiter;

   localparam int AW = 5;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          exu_valid, exu_ready, exu_wen;
   logic [AW-1:0] exu_rd;
   logic [DW-1:0] exu_data;
   logic          lsu_valid, lsu_ready, lsu_wen;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          gpr_w_en;
   logic [AW-1:0] gpr_w_addr;
   logic [DW-1:0] gpr_w_data;
   logic [63:0]   retire_cnt;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   logic [63:0]   exp_cnt;

   always #5 clk = ~clk;

   gpr_writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
      .exu_rd(exu_rd), .exu_data(exu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .gpr_w_en(gpr_w_en), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data),
      .retire_cnt(retire_cnt), .busy(busy)
   );

   typedef struct {
      logic          ev;  logic ew; logic [AW-1:0] er; logic [DW-1:0] ed;
      logic          lv;  logic lw; logic [AW-1:0] lr; logic [DW-1:0] ld;
      logic          en1; logic [AW-1:0] a1; logic [DW-1:0] d1;
      logic          en2; logic [AW-1:0] a2; logic [DW-1:0] d2;
      int            inc;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int  e_sent, l_sent, nw, e_idx, l_idx, first_w, last_w;
      byte c;
      string pat;

      // single EXU write; first write observed two edges after handshake
      vecs[0] = '{1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 64'h0,
                  1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd5, 64'hDEAD_BEEF, 1};
      // EXU to x0 and LSU retire-only: no pulses, two retirements, LSU first
      vecs[1] = '{1'b1, 1'b1, 5'd0, 64'h11, 1'b1, 1'b0, 5'd7, 64'h22,
                  1'b0, 5'd7, 64'h22, 1'b0, 5'd0, 64'h11, 2};
      // both write: LSU first, EXU next cycle
      vecs[2] = '{1'b1, 1'b1, 5'd3, 64'hAAAA, 1'b1, 1'b1, 5'd4, 64'hBBBB,
                  1'b1, 5'd4, 64'hBBBB, 1'b1, 5'd3, 64'hAAAA, 2};
      // LSU alone to x31 with all-ones data
      vecs[3] = '{1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 5'd31, {64{1'b1}},
                  1'b1, 5'd31, {64{1'b1}}, 1'b0, 5'd31, {64{1'b1}}, 1};
      // EXU retire-only: address/data still loaded, enable stays low
      vecs[4] = '{1'b1, 1'b0, 5'd1, 64'h44, 1'b0, 1'b0, 5'd0, 64'h0,
                  1'b0, 5'd1, 64'h44, 1'b0, 5'd1, 64'h44, 1};

      exu_valid = 1'b0; exu_wen = 1'b0; exu_rd = '0; exu_data = '0;
      lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_rd = '0; lsu_data = '0;
      rst_n = 1'b0;
      exp_cnt = 64'd0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst gpr_w_en", {63'd0, gpr_w_en}, 64'd0);
      chk("rst gpr_w_addr", {59'd0, gpr_w_addr}, 64'd0);
      chk("rst gpr_w_data", gpr_w_data, 64'd0);
      chk("rst retire_cnt", retire_cnt, 64'd0);
      chk("rst busy", {63'd0, busy}, 64'd0);
      chk("rst exu_ready", {63'd0, exu_ready}, 64'd0);
      chk("rst lsu_ready", {63'd0, lsu_ready}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-rst exu_ready", {63'd0, exu_ready}, 64'd1);
      chk("post-rst lsu_ready", {63'd0, lsu_ready}, 64'd1);

      // table-driven vectors
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         exu_valid = vecs[i].ev; exu_wen = vecs[i].ew; exu_rd = vecs[i].er; exu_data = vecs[i].ed;
         lsu_valid = vecs[i].lv; lsu_wen = vecs[i].lw; lsu_rd = vecs[i].lr; lsu_data = vecs[i].ld;
         chk($sformatf("vec%0d exu_ready", i), {63'd0, exu_ready}, 64'd1);
         chk($sformatf("vec%0d lsu_ready", i), {63'd0, lsu_ready}, 64'd1);
         @(negedge clk);
         exu_valid = 1'b0; lsu_valid = 1'b0;
         chk($sformatf("vec%0d en after 1 edge", i), {63'd0, gpr_w_en}, 64'd0);
         @(negedge clk);
         chk($sformatf("vec%0d en1", i), {63'd0, gpr_w_en}, {63'd0, vecs[i].en1});
         chk($sformatf("vec%0d addr1", i), {59'd0, gpr_w_addr}, {59'd0, vecs[i].a1});
         chk($sformatf("vec%0d data1", i), gpr_w_data, vecs[i].d1);
         @(negedge clk);
         chk($sformatf("vec%0d en2", i), {63'd0, gpr_w_en}, {63'd0, vecs[i].en2});
         chk($sformatf("vec%0d addr2", i), {59'd0, gpr_w_addr}, {59'd0, vecs[i].a2});
         chk($sformatf("vec%0d data2", i), gpr_w_data, vecs[i].d2);
         @(negedge clk);
         exp_cnt = exp_cnt + 64'(vecs[i].inc);
         chk($sformatf("vec%0d retire_cnt", i), retire_cnt, exp_cnt);
         chk($sformatf("vec%0d busy idle", i), {63'd0, busy}, 64'd0);
      end

      // both sources streaming 10 results each: L,L,L,E pattern, 1 write/cycle
      pat = "LLLELLLELLLELEEEEEEE";
      e_sent = 0; l_sent = 0; nw = 0; e_idx = 0; l_idx = 0; first_w = 0; last_w = 0;
      for (int cyc = 0; cyc < 80 && nw < 20; cyc++) begin
         @(negedge clk);
         if (gpr_w_en) begin
            if (nw == 0) first_w = cyc;
            last_w = cyc;
            c = pat[nw];
            if (c == "L") begin
               chk($sformatf("dual w%0d addr", nw), {59'd0, gpr_w_addr}, 64'd20);
               chk($sformatf("dual w%0d data", nw), gpr_w_data, 64'h2000 + 64'(l_idx));
               l_idx++;
            end else begin
               chk($sformatf("dual w%0d addr", nw), {59'd0, gpr_w_addr}, 64'd10);
               chk($sformatf("dual w%0d data", nw), gpr_w_data, 64'h1000 + 64'(e_idx));
               e_idx++;
            end
            nw++;
         end
         exu_valid = (e_sent < 10); exu_wen = 1'b1; exu_rd = 5'd10; exu_data = 64'h1000 + 64'(e_sent);
         lsu_valid = (l_sent < 10); lsu_wen = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h2000 + 64'(l_sent);
         if (exu_valid && exu_ready) e_sent++;
         if (lsu_valid && lsu_ready) l_sent++;
      end
      exu_valid = 1'b0; lsu_valid = 1'b0;
      chk("dual write count", 64'(nw), 64'd20);
      chk("dual throughput span", 64'(last_w - first_w), 64'd19);
      repeat (2) @(negedge clk);
      exp_cnt = exp_cnt + 64'd20;
      chk("dual retire_cnt", retire_cnt, exp_cnt);

      // EXU streaming alone for 8 cycles: ready stays high, 8 back-to-back writes
      e_sent = 0; nw = 0; first_w = 0; last_w = 0;
      for (int cyc = 0; cyc < 40 && nw < 8; cyc++) begin
         @(negedge clk);
         if (gpr_w_en) begin
            if (nw == 0) first_w = cyc;
            last_w = cyc;
            chk($sformatf("exu stream w%0d addr", nw), {59'd0, gpr_w_addr}, 64'd12);
            chk($sformatf("exu stream w%0d data", nw), gpr_w_data, 64'h3000 + 64'(nw));
            nw++;
         end
         exu_valid = (e_sent < 8); exu_wen = 1'b1; exu_rd = 5'd12; exu_data = 64'h3000 + 64'(e_sent);
         if (exu_valid) begin
            chk($sformatf("exu stream ready c%0d", cyc), {63'd0, exu_ready}, 64'd1);
            if (exu_ready) e_sent++;
         end
      end
      exu_valid = 1'b0;
      chk("exu stream count", 64'(nw), 64'd8);
      chk("exu stream span", 64'(last_w - first_w), 64'd7);
      repeat (2) @(negedge clk);
      exp_cnt = exp_cnt + 64'd8;
      chk("exu stream retire_cnt", retire_cnt, exp_cnt);

      // reset asserted the cycle after both slots load
      @(negedge clk);
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd2; exu_data = 64'h55;
      lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_rd = 5'd3; lsu_data = 64'h66;
      @(negedge clk);
      exu_valid = 1'b0; lsu_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_cnt = 64'd0;
      chk("midrst gpr_w_en", {63'd0, gpr_w_en}, 64'd0);
      chk("midrst gpr_w_addr", {59'd0, gpr_w_addr}, 64'd0);
      chk("midrst gpr_w_data", gpr_w_data, 64'd0);
      chk("midrst retire_cnt", retire_cnt, exp_cnt);
      chk("midrst busy", {63'd0, busy}, 64'd0);
      chk("midrst exu_ready", {63'd0, exu_ready}, 64'd0);
      chk("midrst lsu_ready", {63'd0, lsu_ready}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst release exu_ready", {63'd0, exu_ready}, 64'd1);
      chk("midrst release lsu_ready", {63'd0, lsu_ready}, 64'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("midrst no write c%0d", k), {63'd0, gpr_w_en}, 64'd0);
         @(negedge clk);
      end
      chk("midrst retire_cnt after", retire_cnt, exp_cnt);

      // retire counter wraps from all-ones to zero
      force dut.cnt_q = {64{1'b1}};
      #1;
      release dut.cnt_q;
      @(negedge clk);
      chk("wrap preload", retire_cnt, {64{1'b1}});
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd9; exu_data = 64'h77;
      @(negedge clk);
      exu_valid = 1'b0;
      @(negedge clk);
      chk("wrap retire_cnt", retire_cnt, 64'd0);
      chk("wrap gpr_w_en", {63'd0, gpr_w_en}, 64'd1);
      chk("wrap gpr_w_data", gpr_w_data, 64'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
